// File: rtl/branch_resolve_ctrl_if.sv
// Decode/fetch-facing handshake bundle for the branch resolution controller.
// Latency: none, wires only.
// Backpressure: carries br_ready and redir_ready; the slave modport is the controller side.
interface branch_resolve_ctrl_if #(
    parameter int PC_W = 32
);
    logic            br_valid;
    logic            br_ready;
    logic [3:0]      br_op;
    logic [PC_W-1:0] br_target;
    logic            op_ready;
    logic            cmp_ne;
    logic [3:0]      cmp_sign;
    logic            ds_issued;
    logic            id_stall;
    logic            redir_valid;
    logic            redir_ready;
    logic [PC_W-1:0] redir_pc;
    logic            flush;
    logic            ds_kill;

    modport master (
        output br_valid, br_op, br_target, op_ready, cmp_ne, cmp_sign,
               ds_issued, redir_ready, flush,
        input  br_ready, id_stall, redir_valid, redir_pc, ds_kill
    );

    modport slave (
        input  br_valid, br_op, br_target, op_ready, cmp_ne, cmp_sign,
               ds_issued, redir_ready, flush,
        output br_ready, id_stall, redir_valid, redir_pc, ds_kill
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolver: accept, wait operands, wait delay slot, redirect fetch; BRANCH_LIKELY_EN adds likely ops.
// Latency: resolves 1 cycle after accept with operands ready; redirect offered once the delay slot has issued.
// Backpressure: br_ready only in IDLE, id_stall while operands pend, REDIR held until redir_ready; flush overrides all.
module branch_resolve_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    branch_resolve_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     taken_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OP = 2'd1,
        WAIT_DS = 2'd2,
        REDIR   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]      op;
        logic [PC_W-1:0] target;
    } br_req_t;

    state_t           state_q;
    state_t           state_d;
    br_req_t          req_q;
    logic             ds_seen_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept_vld;
    logic             resolve_vld;
    logic             taken;
`ifdef BRANCH_LIKELY_EN
    logic             likely_op;
    logic             ds_kill_q;
`endif

    // Condition decode runs off the latched op and the live comparator outputs.
    always_comb begin
        taken = 1'b0;
`ifdef BRANCH_LIKELY_EN
        likely_op = 1'b0;
`endif
        case (req_q.op)
            4'd0:    taken = ~bus.cmp_ne;
            4'd1:    taken = bus.cmp_ne;
            4'd2:    taken = bus.cmp_sign[3];
            4'd3:    taken = bus.cmp_sign[2];
            4'd4:    taken = bus.cmp_sign[1];
            4'd5:    taken = bus.cmp_sign[0];
            4'd6:    taken = 1'b1;
            4'd7:    taken = 1'b1;
`ifdef BRANCH_LIKELY_EN
            4'd8:    begin taken = ~bus.cmp_ne;      likely_op = 1'b1; end
            4'd9:    begin taken = bus.cmp_ne;       likely_op = 1'b1; end
            4'd10:   begin taken = bus.cmp_sign[3];  likely_op = 1'b1; end
            4'd11:   begin taken = bus.cmp_sign[2];  likely_op = 1'b1; end
`endif
            default: taken = 1'b0;
        endcase
    end

    assign accept_vld  = (state_q == IDLE) && bus.br_valid && !bus.flush;
    assign resolve_vld = (state_q == WAIT_OP) && bus.op_ready && !bus.flush;

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.br_valid) state_d = WAIT_OP;
                WAIT_OP: if (bus.op_ready) state_d = taken ? WAIT_DS : IDLE;
                WAIT_DS: if (bus.ds_issued || ds_seen_q) state_d = REDIR;
                REDIR:   if (bus.redir_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            ds_seen_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept_vld) begin
                req_q <= '{op: bus.br_op, target: bus.br_target};
            end
            if (bus.flush || accept_vld) begin
                ds_seen_q <= 1'b0;
            end else if (state_q != IDLE && bus.ds_issued) begin
                ds_seen_q <= 1'b1;
            end
            if (resolve_vld && taken && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef BRANCH_LIKELY_EN
    // A not-taken likely branch annuls its delay slot in the cycle after resolution.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_kill_q <= 1'b0;
        end else begin
            ds_kill_q <= resolve_vld && likely_op && !taken;
        end
    end
    assign bus.ds_kill = ds_kill_q;
`else
    assign bus.ds_kill = 1'b0;
`endif

    assign bus.br_ready    = (state_q == IDLE) && !bus.flush;
    assign bus.id_stall    = (state_q == WAIT_OP) && !bus.op_ready;
    assign bus.redir_valid = (state_q == REDIR);
    assign bus.redir_pc    = req_q.target;
    assign taken_cnt       = cnt_q;

endmodule
